// File: rtl/koa_pkg.sv
// Shared types and elaboration helpers for the Karatsuba sequential multiplier.
package koa_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    MUL_L = 3'd1,
    MUL_H = 3'd2,
    MUL_M = 3'd3,
    COMB  = 3'd4,
    DONE  = 3'd5
  } state_t;

  function automatic int unsigned half_w(input int unsigned sw);
    return sw / 2;
  endfunction

  function automatic bit sw_legal(input int unsigned sw);
    return (sw >= 4) && ((sw % 2) == 0);
  endfunction

endpackage

// File: rtl/koa_half_mult.sv
// Combinational (H+1)x(H+1) unsigned multiplier shared by all Karatsuba partial products.
module koa_half_mult
  import koa_pkg::*;
#(
  parameter int unsigned H             = 12,
  parameter int unsigned Opt_FPGA_ASIC = 0
) (
  input  logic [H:0]     a,
  input  logic [H:0]     b,
  output logic [2*H+1:0] p
);

  localparam int unsigned MW = H + 1;
  localparam int unsigned PW = 2 * H + 2;

  generate
    if (Opt_FPGA_ASIC == 1) begin : g_fpga
      // Plain operator so the FPGA flow maps it onto DSP slices.
      assign p = PW'(a) * PW'(b);
    end else begin : g_asic
      // Explicit shift-add array, left for the ASIC flow to restructure.
      always_comb begin
        p = '0;
        for (int i = 0; i < int'(MW); i++) begin
          if (b[i]) p = p + (PW'(a) << i);
        end
      end
    end
  endgenerate

endmodule

// File: rtl/koa_seq_mult.sv
// Multicycle Karatsuba significand multiplier: three shared-multiplier passes then a combine cycle.
module koa_seq_mult
  import koa_pkg::*;
#(
  parameter int unsigned SW            = 24,
  parameter int unsigned Opt_FPGA_ASIC = 0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid_i,
  output logic            in_ready_o,
  input  logic [SW-1:0]   Data_A_i,
  input  logic [SW-1:0]   Data_B_i,
  output logic            out_valid_o,
  input  logic            out_ready_i,
  output logic [2*SW-1:0] sgf_result_o,
  output logic            busy_o
);

  localparam int unsigned H   = half_w(SW);
  localparam int unsigned MW  = H + 1;
  localparam int unsigned PW  = 2 * H + 2;
  localparam int unsigned MDW = 2 * H + 1;
  localparam int unsigned RW  = 2 * SW;

  generate
    if (!sw_legal(SW)) begin : g_sw_check
      $error("koa_seq_mult: SW must be even and >= 4");
    end
  endgenerate

  state_t            state_q, state_d;
  logic              accept;
  logic [SW-1:0]     a_q, b_q;
  logic [2*H-1:0]    p0_q, p2_q;
  logic [PW-1:0]     p1_q;
  logic [MW-1:0]     mul_a, mul_b;
  logic [PW-1:0]     mul_p;
  logic [MDW-1:0]    mid;
  logic [RW-1:0]     result_c;

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (in_valid_i) state_d = MUL_L;
      MUL_L:   state_d = MUL_H;
      MUL_H:   state_d = MUL_M;
      MUL_M:   state_d = COMB;
      COMB:    state_d = DONE;
      DONE:    if (out_ready_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    in_ready_o = (state_q == IDLE) & ~rst;
    busy_o     = (state_q != IDLE);
    accept     = in_valid_i & (state_q == IDLE) & ~rst;
  end

  // Shared multiplier operand select: low halves, high halves, then half sums
  always_comb begin
    mul_a = '0;
    mul_b = '0;
    case (state_q)
      MUL_L: begin
        mul_a = MW'(a_q[H-1:0]);
        mul_b = MW'(b_q[H-1:0]);
      end
      MUL_H: begin
        mul_a = MW'(a_q[SW-1:H]);
        mul_b = MW'(b_q[SW-1:H]);
      end
      MUL_M: begin
        mul_a = MW'(a_q[SW-1:H]) + MW'(a_q[H-1:0]);
        mul_b = MW'(b_q[SW-1:H]) + MW'(b_q[H-1:0]);
      end
      default: ;
    endcase
  end

  koa_half_mult #(
    .H             (H),
    .Opt_FPGA_ASIC (Opt_FPGA_ASIC)
  ) u_mult (
    .a (mul_a),
    .b (mul_b),
    .p (mul_p)
  );

  // Karatsuba combine; P2 and P0 occupy disjoint halves so they concatenate
  always_comb begin
    mid      = MDW'(p1_q - PW'(p0_q) - PW'(p2_q));
    result_c = {p2_q, p0_q} + (RW'(mid) << H);
  end

  // Operand, partial-product and result registers
  always_ff @(posedge clk) begin
    if (rst) begin
      a_q          <= '0;
      b_q          <= '0;
      p0_q         <= '0;
      p1_q         <= '0;
      p2_q         <= '0;
      sgf_result_o <= '0;
      out_valid_o  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (accept) begin
          a_q <= Data_A_i;
          b_q <= Data_B_i;
        end
        MUL_L: p0_q <= mul_p[2*H-1:0];
        MUL_H: p2_q <= mul_p[2*H-1:0];
        MUL_M: p1_q <= mul_p;
        COMB: begin
          sgf_result_o <= result_c;
          out_valid_o  <= 1'b1;
        end
        DONE: if (out_ready_i) out_valid_o <= 1'b0;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_koa_seq_mult.sv
// Directed and light random bench for koa_seq_mult at SW=24.
module tb_koa_seq_mult;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid_i;
  logic        in_ready_o;
  logic [23:0] Data_A_i;
  logic [23:0] Data_B_i;
  logic        out_valid_o;
  logic        out_ready_i;
  logic [47:0] sgf_result_o;
  logic        busy_o;

  int checks   = 0;
  int failures = 0;

  koa_seq_mult #(.SW(24), .Opt_FPGA_ASIC(0)) dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid_i   (in_valid_i),
    .in_ready_o   (in_ready_o),
    .Data_A_i     (Data_A_i),
    .Data_B_i     (Data_B_i),
    .out_valid_o  (out_valid_o),
    .out_ready_i  (out_ready_i),
    .sgf_result_o (sgf_result_o),
    .busy_o       (busy_o)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Accept one operation and wait for out_valid_o; lat = -1 on timeout.
  task automatic drive_op(input logic [23:0] a, input logic [23:0] b, input bit toggle,
                          output int lat, output logic [47:0] res);
    int w;
    lat = -1;
    res = '0;
    w   = 0;
    while (!in_ready_o && w < 20) begin
      @(posedge clk); #1;
      w++;
    end
    if (!in_ready_o) return;
    in_valid_i = 1'b1;
    Data_A_i   = a;
    Data_B_i   = b;
    @(posedge clk); #1;
    in_valid_i = 1'b0;
    for (int n = 1; n <= 10; n++) begin
      if (toggle) begin
        Data_A_i = ~Data_A_i ^ 24'(n);
        Data_B_i = Data_B_i + 24'h111111;
      end
      @(posedge clk); #1;
      if (out_valid_o) begin
        lat = n;
        res = sgf_result_o;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid_i = 1'b0; out_ready_i = 1'b1;
    Data_A_i = '0; Data_B_i = '0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    checks++;
    if (in_ready_o !== 1'b0) begin failures++; $display("FAIL reset_in_ready got=%b exp=0", in_ready_o); end
    checks++;
    if (out_valid_o !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", out_valid_o); end
    checks++;
    if (sgf_result_o !== 48'h0) begin failures++; $display("FAIL reset_result got=%h exp=0", sgf_result_o); end
    checks++;
    if (busy_o !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy_o); end
    rst = 1'b0;
    #1;
    checks++;
    if (in_ready_o !== 1'b1) begin failures++; $display("FAIL post_reset_in_ready got=%b exp=1", in_ready_o); end
  endtask

  task automatic test_corners();
    logic [23:0] va [4] = '{24'hFFFFFF, 24'h800000, 24'h000000, 24'h000001};
    logic [23:0] vb [4] = '{24'hFFFFFF, 24'h800000, 24'hABCDEF, 24'hABCDEF};
    logic [47:0] ve [4] = '{48'hFFFFFE000001, 48'h400000000000, 48'h000000000000, 48'h000000ABCDEF};
    int lat;
    logic [47:0] res;
    out_ready_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      drive_op(va[i], vb[i], 1'b0, lat, res);
      checks++;
      if (lat !== 4) begin failures++; $display("FAIL corner%0d_latency got=%0d exp=4", i, lat); end
      checks++;
      if (res !== ve[i]) begin failures++; $display("FAIL corner%0d_result got=%h exp=%h", i, res, ve[i]); end
      @(posedge clk); #1;
      checks++;
      if (in_ready_o !== 1'b1 || out_valid_o !== 1'b0) begin
        failures++;
        $display("FAIL corner%0d_return_idle in_ready=%b out_valid=%b exp=1/0", i, in_ready_o, out_valid_o);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [47:0] exp1 = 48'h123456 * 48'h00ABCD;
    logic [47:0] exp2 = 48'h00000E1000;
    int lat;
    logic [47:0] res;
    out_ready_i = 1'b0;
    drive_op(24'h123456, 24'h00ABCD, 1'b0, lat, res);
    checks++;
    if (lat !== 4 || res !== exp1) begin
      failures++;
      $display("FAIL bp_first lat=%0d res=%h exp lat=4 res=%h", lat, res, exp1);
    end
    in_valid_i = 1'b1; Data_A_i = 24'h000F00; Data_B_i = 24'h0000F0;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      checks++;
      if (out_valid_o !== 1'b1 || sgf_result_o !== exp1 || in_ready_o !== 1'b0 || busy_o !== 1'b1) begin
        failures++;
        $display("FAIL bp_hold%0d out_valid=%b res=%h in_ready=%b busy=%b exp 1/%h/0/1",
                 c, out_valid_o, sgf_result_o, in_ready_o, busy_o, exp1);
      end
    end
    out_ready_i = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (out_valid_o !== 1'b0 || in_ready_o !== 1'b1) begin
      failures++;
      $display("FAIL bp_release out_valid=%b in_ready=%b exp 0/1", out_valid_o, in_ready_o);
    end
    @(posedge clk); #1;
    in_valid_i = 1'b0;
    checks++;
    if (busy_o !== 1'b1) begin failures++; $display("FAIL bp_next_accept busy=%b exp=1", busy_o); end
    lat = -1;
    for (int n = 1; n <= 10; n++) begin
      @(posedge clk); #1;
      if (out_valid_o) begin lat = n; break; end
    end
    checks++;
    if (lat !== 4 || sgf_result_o !== exp2) begin
      failures++;
      $display("FAIL bp_second lat=%0d res=%h exp lat=4 res=%h", lat, sgf_result_o, exp2);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid();
    int lat;
    logic [47:0] res;
    bit seen;
    out_ready_i = 1'b1;
    in_valid_i = 1'b1; Data_A_i = 24'h00FFFF; Data_B_i = 24'h00FFFF;
    @(posedge clk); #1;
    in_valid_i = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (out_valid_o !== 1'b0 || sgf_result_o !== 48'h0 || busy_o !== 1'b0 || in_ready_o !== 1'b0) begin
      failures++;
      $display("FAIL midreset_outputs out_valid=%b res=%h busy=%b in_ready=%b exp all 0",
               out_valid_o, sgf_result_o, busy_o, in_ready_o);
    end
    rst = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 8; c++) begin
      @(posedge clk); #1;
      if (out_valid_o) seen = 1'b1;
    end
    checks++;
    if (seen !== 1'b0) begin failures++; $display("FAIL midreset_no_valid seen=%b exp=0", seen); end
    drive_op(24'd3, 24'd5, 1'b0, lat, res);
    checks++;
    if (lat !== 4 || res !== 48'd15) begin
      failures++;
      $display("FAIL midreset_followup lat=%0d res=%h exp lat=4 res=f", lat, res);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_toggle();
    logic [47:0] exp = 48'h123456 * 48'h654321;
    int lat;
    logic [47:0] res;
    out_ready_i = 1'b1;
    drive_op(24'h123456, 24'h654321, 1'b1, lat, res);
    checks++;
    if (lat !== 4 || res !== exp) begin
      failures++;
      $display("FAIL toggle_inputs lat=%0d res=%h exp lat=4 res=%h", lat, res, exp);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_random();
    logic [23:0] a, b;
    logic [47:0] exp, res;
    int lat, results;
    bit stall;
    results = 0;
    for (int i = 0; i < 150; i++) begin
      a = 24'($urandom);
      b = 24'($urandom);
      if (i == 0) a = 24'hFFFFFF;
      exp = {24'b0, a} * {24'b0, b};
      stall = 1'($urandom_range(0, 1));
      out_ready_i = ~stall;
      drive_op(a, b, 1'b0, lat, res);
      if (lat == 4) results++;
      checks++;
      if (lat !== 4 || res !== exp) begin
        failures++;
        $display("FAIL random%0d a=%h b=%h lat=%0d res=%h exp lat=4 res=%h", i, a, b, lat, res, exp);
      end
      if (stall) begin
        repeat ($urandom_range(1, 3)) begin @(posedge clk); #1; end
        checks++;
        if (out_valid_o !== 1'b1 || sgf_result_o !== exp) begin
          failures++;
          $display("FAIL random%0d_stall out_valid=%b res=%h exp 1/%h", i, out_valid_o, sgf_result_o, exp);
        end
        out_ready_i = 1'b1;
      end
      @(posedge clk); #1;
      checks++;
      if (out_valid_o !== 1'b0) begin
        failures++;
        $display("FAIL random%0d_dup out_valid=%b exp=0", i, out_valid_o);
      end
    end
    checks++;
    if (results !== 150) begin failures++; $display("FAIL random_count got=%0d exp=150", results); end
  endtask

  initial begin
    test_reset();
    test_corners();
    test_backpressure();
    test_reset_mid();
    test_toggle();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
